btn_cnt_multi: RTL and testbench

- Parametrised successor to the single-button 16-bit press counter.
- Counts debounced rising edges on N independent button inputs, one WIDTH-bit counter per channel.
- Per-channel wrap/saturate mode, synchronous clear and sticky overflow flag.
- Sits between raw board buttons and display/readout logic; all button inputs are asynchronous to CLK.

---
 rtl/cnt_pkg.sv | 17 +
 rtl/btn_debounce.sv | 56 +++++
 rtl/btn_cnt_multi.sv | 129 ++++++++++++
 tb/tb_btn_cnt_multi.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_pkg.sv
// cnt_pkg: counter mode constants, default sizes and the counter-max helper
// shared by the button press counter blocks.
package cnt_pkg;

  localparam logic CNT_WRAP = 1'b0;
  localparam logic CNT_SAT  = 1'b1;

  localparam int unsigned DEF_N        = 2;
  localparam int unsigned DEF_WIDTH    = 16;
  localparam int unsigned DEF_DEBOUNCE = 16;

  // All-ones value of a counter 'width' bits wide (width 1..32).
  function automatic logic [31:0] cnt_max(input int unsigned width);
    return 32'hFFFF_FFFF >> (32 - width);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser, stability counter and debounced level for one
// asynchronous button; RISE pulses for one cycle when LEVEL goes 0->1.
module btn_debounce
  import cnt_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN,
  output logic LEVEL,
  output logic RISE
);

  localparam int unsigned     CW       = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE - 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;

  always_comb begin
    sync_d  = {sync_q[0], BTN};
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    // Count only while the synchronised level disagrees; any agreement restarts it.
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
        rise_d  = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign LEVEL = level_q;
  assign RISE  = rise_q;

endmodule

// File: rtl/btn_cnt_multi.sv
// btn_cnt_multi: N debounced button press counters with per-channel wrap/saturate,
// clear and sticky overflow. Define BTN_CNT_REPEAT_EN for hold-to-auto-repeat.
module btn_cnt_multi
  import cnt_pkg::*;
#(
  parameter int unsigned  N        = DEF_N,
  parameter int unsigned  WIDTH    = DEF_WIDTH,
  parameter int unsigned  DEBOUNCE = DEF_DEBOUNCE,
  parameter logic [N-1:0] SAT      = '0
`ifdef BTN_CNT_REPEAT_EN
  ,
  parameter int unsigned  HOLD     = 1000,
  parameter int unsigned  RATE     = 250
`endif
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N-1:0]         BTN,
  input  logic [N-1:0]         CLR,
  output logic [N*WIDTH-1:0]   VAL,
  output logic [N-1:0]         OVF,
  output logic [N-1:0]         PRESS
);

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(cnt_max(WIDTH));

  logic [N-1:0]     level, rise, press_ev;
  logic [WIDTH-1:0] val_q [N];
  logic [WIDTH-1:0] val_d [N];
  logic [N-1:0]     ovf_q, ovf_d;
  logic [N-1:0]     press_q, press_d;

  for (genvar i = 0; i < N; i++) begin : g_ch
    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
      .CLK   (CLK),
      .RST   (RST),
      .BTN   (BTN[i]),
      .LEVEL (level[i]),
      .RISE  (rise[i])
    );
    assign VAL[i*WIDTH +: WIDTH] = val_q[i];
  end

`ifdef BTN_CNT_REPEAT_EN
  localparam int unsigned   TMR_MAX = (HOLD > RATE) ? HOLD : RATE;
  localparam int unsigned   TW      = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TW-1:0] HOLD_LD = TW'(HOLD - 1);
  localparam logic [TW-1:0] RATE_LD = TW'(RATE - 1);

  logic [TW-1:0] tmr_q [N];
  logic [TW-1:0] tmr_d [N];
  logic [N-1:0]  rep_act_q, rep_act_d, rep_ev;

  always_comb begin
    tmr_d     = tmr_q;
    rep_act_d = rep_act_q;
    rep_ev    = '0;
    for (int i = 0; i < N; i++) begin
      if (CLR[i] || !level[i]) begin
        rep_act_d[i] = 1'b0;
        tmr_d[i]     = HOLD_LD;
      end else if (rise[i]) begin
        rep_act_d[i] = 1'b1;
        tmr_d[i]     = HOLD_LD;
      end else if (rep_act_q[i]) begin
        // Terminal count fires a repeat and reloads with the repeat period.
        if (tmr_q[i] == '0) begin
          rep_ev[i] = 1'b1;
          tmr_d[i]  = RATE_LD;
        end else begin
          tmr_d[i] = tmr_q[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < N; i++) tmr_q[i] <= HOLD_LD;
      rep_act_q <= '0;
    end else begin
      tmr_q     <= tmr_d;
      rep_act_q <= rep_act_d;
    end
  end

  assign press_ev = rise | rep_ev;
`else
  logic unused_level;
  assign unused_level = ^level;
  assign press_ev     = rise;
`endif

  always_comb begin
    val_d   = val_q;
    ovf_d   = ovf_q;
    press_d = press_ev;
    for (int i = 0; i < N; i++) begin
      // Clear wins over a coincident press; the press is dropped but still pulses PRESS.
      if (CLR[i]) begin
        val_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (press_ev[i]) begin
        if (val_q[i] == CNT_MAX) begin
          ovf_d[i] = 1'b1;
          val_d[i] = (SAT[i] == CNT_SAT) ? CNT_MAX : '0;
        end else begin
          val_d[i] = val_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < N; i++) val_q[i] <= '0;
      ovf_q   <= '0;
      press_q <= '0;
    end else begin
      val_q   <= val_d;
      ovf_q   <= ovf_d;
      press_q <= press_d;
    end
  end

  assign OVF   = ovf_q;
  assign PRESS = press_q;

endmodule

// File: tb/tb_btn_cnt_multi.sv
// tb_btn_cnt_multi: directed and randomised stimulus for btn_cnt_multi, checked every
// cycle against a behavioural model of debounce, counting, clear and auto-repeat.
`timescale 1ns/1ps
module tb_btn_cnt_multi;

  localparam int          N_CH  = 2;
  localparam int          W     = 4;
  localparam int          DB    = 4;
  localparam logic [1:0]  SATV  = 2'b10;
  localparam int          MAXV  = (1 << W) - 1;
`ifdef BTN_CNT_REPEAT_EN
  localparam int          HOLD  = 20;
  localparam int          RATE  = 5;
`endif

  logic              CLK = 1'b0;
  logic              RST;
  logic [N_CH-1:0]   BTN, CLR;
  logic [N_CH*W-1:0] VAL;
  logic [N_CH-1:0]   OVF, PRESS;

  always #5 CLK = ~CLK;

  btn_cnt_multi #(
    .N(N_CH), .WIDTH(W), .DEBOUNCE(DB), .SAT(SATV)
`ifdef BTN_CNT_REPEAT_EN
    , .HOLD(HOLD), .RATE(RATE)
`endif
  ) dut (
    .CLK(CLK), .RST(RST), .BTN(BTN), .CLR(CLR),
    .VAL(VAL), .OVF(OVF), .PRESS(PRESS)
  );

  int n_pass = 0;
  int n_total = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: each edge sees the raw level from two edges earlier; the debounced level
  // flips after DB consecutive disagreeing samples; a 0->1 flip is a press next edge.
  logic [N_CH-1:0] m_hist[$];
  int m_val [N_CH];
  int m_run [N_CH];
  bit m_ovf [N_CH];
  bit m_press [N_CH];
  bit m_deb [N_CH];
  bit m_pend [N_CH];
  bit m_act [N_CH];
  int m_age [N_CH];

  task automatic model_reset();
    m_hist = {};
    m_hist.push_back('0);
    m_hist.push_back('0);
    for (int i = 0; i < N_CH; i++) begin
      m_val[i] = 0; m_run[i] = 0; m_ovf[i] = 0; m_press[i] = 0;
      m_deb[i] = 0; m_pend[i] = 0; m_act[i] = 0; m_age[i] = 0;
    end
  endtask

  task automatic model_step();
    logic [N_CH-1:0] lv;
    bit fire;
    lv = m_hist.pop_front();
    m_hist.push_back(BTN);
    for (int i = 0; i < N_CH; i++) begin
      fire = m_pend[i];
`ifdef BTN_CNT_REPEAT_EN
      if (m_act[i]) begin
        if (!m_deb[i] || CLR[i]) m_act[i] = 0;
        else begin
          m_age[i]++;
          if (m_age[i] >= HOLD && (m_age[i] - HOLD) % RATE == 0) fire = 1;
        end
      end
      if (m_pend[i]) begin
        m_act[i] = !CLR[i];
        m_age[i] = 0;
      end
`endif
      m_press[i] = fire;
      if (CLR[i]) begin
        m_val[i] = 0;
        m_ovf[i] = 0;
      end else if (fire) begin
        if (m_val[i] == MAXV) begin
          m_ovf[i] = 1;
          m_val[i] = SATV[i] ? MAXV : 0;
        end else m_val[i]++;
      end
      m_pend[i] = 0;
      if (lv[i] != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_deb[i] = lv[i];
          m_run[i] = 0;
          m_pend[i] = lv[i];
        end
      end else m_run[i] = 0;
    end
  endtask

  always @(posedge CLK or negedge RST) begin
    if (!RST) model_reset();
    else model_step();
  end

  always @(negedge CLK) begin
    if (cmp_on) begin
      for (int i = 0; i < N_CH; i++) begin
        chk($sformatf("val%0d", i), 32'(VAL[i*W +: W]), 32'(m_val[i]));
        chk($sformatf("ovf%0d", i), 32'(OVF[i]), 32'(m_ovf[i]));
        chk($sformatf("press%0d", i), 32'(PRESS[i]), 32'(m_press[i]));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_press(input int ch, input int maxc, output int n);
    n = -1;
    for (int k = 1; k <= maxc; k++) begin
      @(negedge CLK);
      if (PRESS[ch]) begin
        n = k;
        return;
      end
    end
    $display("FAIL wait_press%0d: no PRESS within %0d cycles", ch, maxc);
  endtask

  int n, extra, v0;
  int dur [N_CH];

  initial begin
    RST = 1'b0; BTN = '0; CLR = '0;
    model_reset();
    cmp_on = 1'b1;
    #12;
    chk("rst_val", 32'(VAL), 0);
    chk("rst_ovf", 32'(OVF), 0);
    chk("rst_press", 32'(PRESS), 0);
    #8 RST = 1'b1;

    // Basic press and latency
    @(negedge CLK); BTN[0] = 1'b1;
    wait_press(0, 20, n);
    chk("basic_latency", n, DB + 3);
    chk("basic_val0", 32'(VAL[3:0]), 1);
    chk("basic_val1", 32'(VAL[7:4]), 0);
    chk("model_basic_val0", m_val[0], 1);
    extra = 0;
    repeat (22) begin
      @(negedge CLK);
      if (PRESS[0]) extra++;
    end
`ifdef BTN_CNT_REPEAT_EN
    chk("basic_extra_pulses", extra, 1);
`else
    chk("basic_extra_pulses", extra, 0);
`endif
    BTN[0] = 1'b0; idle(12);

    // Bounce, then settle high: exactly one count
    v0 = int'(VAL[3:0]);
    for (int k = 0; k < 5; k++) begin
      BTN[0] = 1'b1; idle(2);
      BTN[0] = 1'b0; idle(2);
    end
    BTN[0] = 1'b1; idle(15);
    BTN[0] = 1'b0; idle(12);
    chk("bounce_once", 32'(VAL[3:0]), 32'((v0 + 1) % 16));

    // Glitch shorter than DB: no count
    v0 = int'(VAL[3:0]);
    BTN[0] = 1'b1; idle(3);
    BTN[0] = 1'b0; idle(12);
    chk("glitch_nocount", 32'(VAL[3:0]), 32'(v0));

    CLR = 2'b11; idle(1); CLR = '0;
    chk("clr_val", 32'(VAL), 0);
    chk("clr_ovf", 32'(OVF), 0);

    // 17 presses: ch0 wraps, ch1 saturates
    repeat (17) begin
      BTN = 2'b11; idle(8);
      BTN = 2'b00; idle(8);
    end
    chk("wrap_val0", 32'(VAL[3:0]), 1);
    chk("wrap_ovf0", 32'(OVF[0]), 1);
    chk("sat_val1", 32'(VAL[7:4]), 15);
    chk("sat_ovf1", 32'(OVF[1]), 1);
    chk("model_sat_val1", m_val[1], 15);

    // CLR in the same cycle as a ch1 press
    BTN[1] = 1'b1; idle(6);
    CLR[1] = 1'b1; idle(1);
    chk("clrpri_val1", 32'(VAL[7:4]), 0);
    chk("clrpri_ovf1", 32'(OVF[1]), 0);
    chk("clrpri_press1", 32'(PRESS[1]), 1);
    chk("clrpri_val0", 32'(VAL[3:0]), 1);
    CLR = '0; BTN[1] = 1'b0; idle(12);

    // Async reset mid-debounce, button held through release
    BTN[0] = 1'b1; idle(4);
    #2 RST = 1'b0;
    #1;
    chk("async_rst_val", 32'(VAL), 0);
    chk("async_rst_ovf", 32'(OVF), 0);
    chk("async_rst_press", 32'(PRESS), 0);
    idle(2); RST = 1'b1;
    wait_press(0, 20, n);
    chk("rst_hold_latency", n, DB + 3);
    chk("rst_hold_val0", 32'(VAL[3:0]), 1);
    BTN[0] = 1'b0; idle(12);

`ifdef BTN_CNT_REPEAT_EN
    BTN[0] = 1'b1;
    wait_press(0, 20, n);
    extra = 1;
    repeat (40) begin
      @(negedge CLK);
      if (PRESS[0]) extra++;
    end
    chk("repeat_presses", extra, 6);
    BTN[0] = 1'b0; idle(12);
`endif

    // Randomised mix of bounces, clean presses, long holds and clears
    for (int i = 0; i < N_CH; i++) dur[i] = 0;
    repeat (3000) begin
      @(negedge CLK);
      for (int i = 0; i < N_CH; i++) begin
        if (dur[i] == 0) begin
          BTN[i] = ~BTN[i];
          dur[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(20, 45))
                                                : int'($urandom_range(1, 12));
        end else dur[i]--;
        CLR[i] = ($urandom_range(0, 39) == 0);
      end
    end
    BTN = '0; CLR = '0; idle(12);

    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
